// File: rtl/mem_arbiter.sv
// Arbitrates one shared memory port between the I-cache and D-cache engines.
// D wins by default; a starvation counter eventually forces an I grant.
module mem_arbiter #(
    parameter int unsigned MEM_LAT    = 4,
    parameter int unsigned STARVE_MAX = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [15:0] i_addr,
    output logic        i_grant,
    output logic        i_done,
    input  logic        d_req,
    input  logic        d_wr,
    input  logic [15:0] d_addr,
    input  logic [15:0] d_wdata,
    output logic        d_grant,
    output logic        d_done,
    output logic [15:0] rdata,
    output logic        busy,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic        mem_stall,
    input  logic [15:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t      state_q, state_d;
    logic        owner_q, owner_d;
    logic        wr_q, wr_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic [15:0] rdata_q, rdata_d;
    logic [3:0]  wait_q, wait_d;
    logic [3:0]  lat_q, lat_d;
    logic        gnt_i, gnt_d;
    logic [3:0]  wait_inc;

    assign wait_inc = (wait_q == 4'hF) ? wait_q : wait_q + 4'd1;

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        lat_d   = lat_q;
        wait_d  = i_req ? wait_inc : 4'd0;
        gnt_i   = 1'b0;
        gnt_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                // Grants are gated by rst so every output is 0 during reset.
                if (!rst) begin
                    gnt_i = i_req && (wait_q >= 4'(STARVE_MAX) || !d_req);
                    gnt_d = d_req && !gnt_i;
                end
                if (gnt_i) begin
                    owner_d = 1'b0;
                    wr_d    = 1'b0;
                    addr_d  = i_addr;
                    wdata_d = 16'h0;
                    state_d = ISSUE;
                end else if (gnt_d) begin
                    owner_d = 1'b1;
                    wr_d    = d_wr;
                    addr_d  = d_addr;
                    wdata_d = d_wdata;
                    state_d = ISSUE;
                end
                if (gnt_i || !i_req) wait_d = 4'd0;
                else if (!gnt_d)     wait_d = wait_q;
            end
            ISSUE: begin
                if (!mem_stall) begin
                    lat_d   = 4'(MEM_LAT - 1);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (lat_q == 4'd0) begin
                    if (!wr_q) rdata_d = mem_rdata;
                    state_d = RESP;
                end else begin
                    lat_d = lat_q - 4'd1;
                end
            end
            RESP: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= 16'h0;
            wdata_q <= 16'h0;
            rdata_q <= 16'h0;
            wait_q  <= 4'd0;
            lat_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            wait_q  <= wait_d;
            lat_q   <= lat_d;
        end
    end

    assign i_grant   = gnt_i;
    assign d_grant   = gnt_d;
    assign i_done    = (state_q == RESP) && !owner_q;
    assign d_done    = (state_q == RESP) && owner_q;
    assign busy      = (state_q != IDLE);
    assign rdata     = rdata_q;
    assign mem_rd    = (state_q == ISSUE) && !wr_q;
    assign mem_wr    = (state_q == ISSUE) && wr_q;
    assign mem_addr  = (state_q == ISSUE) ? addr_q : 16'h0;
    assign mem_wdata = (state_q == ISSUE) ? wdata_q : 16'h0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Random traffic bench for mem_arbiter against a transaction-timing model.
module tb_mem_arbiter;

    localparam int LAT = 4;
    localparam int SM  = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req, d_req, d_wr, mem_stall;
    logic [15:0] i_addr, d_addr, d_wdata, mem_rdata;
    logic        i_grant, i_done, d_grant, d_done, busy;
    logic        mem_rd, mem_wr;
    logic [15:0] rdata, mem_addr, mem_wdata;

    mem_arbiter #(.MEM_LAT(LAT), .STARVE_MAX(SM)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr),
        .i_grant(i_grant), .i_done(i_done),
        .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_grant(d_grant), .d_done(d_done),
        .rdata(rdata), .busy(busy),
        .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_stall(mem_stall), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Transaction-level model: in-flight flag, acceptance time, denial count
    bit          m_busy, m_acc_ok, m_own_d, m_wr;
    logic [15:0] m_addr, m_wdata, m_rdata;
    int          m_acc, m_deny, cyc;
    int          starve_wins = 0;

    bit          e_ig, e_dg, e_id, e_dd, e_rd, e_wr;
    logic [15:0] e_addr, e_wd;

    task automatic model_reset();
        m_busy = 0; m_acc_ok = 0; m_own_d = 0; m_wr = 0;
        m_addr = 0; m_wdata = 0; m_rdata = 0; m_acc = 0; m_deny = 0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_hs"}, {59'd0, i_grant, d_grant, i_done, d_done, busy}, 64'd0);
        chk({tag, "_mem"}, {30'd0, mem_rd, mem_wr, mem_addr, mem_wdata}, 64'd0);
        chk({tag, "_rdata"}, {48'd0, rdata}, 64'd0);
    endtask

    task automatic cycle_check();
        e_ig = 0; e_dg = 0; e_id = 0; e_dd = 0; e_rd = 0; e_wr = 0;
        e_addr = 0; e_wd = 0;
        if (!m_busy) begin
            e_ig = i_req && (m_deny >= SM || !d_req);
            e_dg = d_req && !e_ig;
        end else if (!m_acc_ok) begin
            e_rd = !m_wr; e_wr = m_wr; e_addr = m_addr; e_wd = m_wdata;
        end else if (cyc == m_acc + LAT + 1) begin
            e_id = !m_own_d; e_dd = m_own_d;
        end
        chk("hs", {59'd0, i_grant, d_grant, i_done, d_done, busy},
                  {59'd0, e_ig, e_dg, e_id, e_dd, m_busy});
        chk("mem", {30'd0, mem_rd, mem_wr, mem_addr, mem_wdata},
                   {30'd0, e_rd, e_wr, e_addr, e_wd});
        chk("rdata", {48'd0, rdata}, {48'd0, m_rdata});
        if (e_ig && d_req) starve_wins++;
        if (!m_busy) begin
            if (e_ig) begin
                m_busy = 1; m_acc_ok = 0; m_own_d = 0; m_wr = 0;
                m_addr = i_addr; m_wdata = 0;
            end else if (e_dg) begin
                m_busy = 1; m_acc_ok = 0; m_own_d = 1; m_wr = d_wr;
                m_addr = d_addr; m_wdata = d_wdata;
            end
            if (e_ig || !i_req) m_deny = 0;
            else if (e_dg)      m_deny = (m_deny < 15) ? m_deny + 1 : 15;
        end else begin
            m_deny = i_req ? ((m_deny < 15) ? m_deny + 1 : 15) : 0;
            if (!m_acc_ok) begin
                if (!mem_stall) begin m_acc_ok = 1; m_acc = cyc; end
            end else if (cyc == m_acc + LAT) begin
                if (!m_wr) m_rdata = mem_rdata;
            end else if (cyc == m_acc + LAT + 1) begin
                m_busy = 0;
            end
        end
    endtask

    task automatic drive(input int mode);
        if (e_ig) i_req = 0;
        if (e_dg) d_req = 0;
        if (!i_req && (mode == 1 || $urandom_range(0, 3) == 0)) begin
            i_req = 1; i_addr = 16'($urandom);
        end
        if (!d_req && (mode == 1 || $urandom_range(0, 2) == 0)) begin
            d_req = 1; d_wr = 1'($urandom); d_addr = 16'($urandom);
            d_wdata = 16'($urandom);
        end
        mem_stall = (mode == 1) ? 1'b0 : ($urandom_range(0, 2) == 0);
        mem_rdata = 16'($urandom);
    endtask

    initial begin
        rst = 1; i_req = 0; d_req = 0; d_wr = 0; mem_stall = 0;
        i_addr = 0; d_addr = 0; d_wdata = 0; mem_rdata = 0;
        e_ig = 0; e_dg = 0;
        model_reset();
        cyc = 0;
        @(posedge clk); #1;
        chk_all_zero("reset");
        @(posedge clk); #1;
        rst = 0;
        drive(0);
        for (int n = 0; n < 2400; n++) begin
            if (n % 500 == 250 && m_busy && m_acc_ok) begin
                #1 rst = 1;
                #1 chk_all_zero("async_rst");
                model_reset();
                e_ig = 0; e_dg = 0;
                @(posedge clk); #1;
                cyc++;
                rst = 0;
            end else begin
                #1 cycle_check();
                @(posedge clk); #1;
                cyc++;
                drive((n >= 600 && n < 1000) ? 1 : 0);
            end
        end
        chk("starve_seen", {63'd0, starve_wins > 0}, 64'd1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Shares the single main-memory port between the instruction-cache and data-cache miss/writeback engines in proc_hier.
- One transaction is in flight at a time.
- The D-cache has priority, because its requester is the older instruction in the memory stage.
- A starvation counter guarantees I-cache progress.
- Sits between both cache controllers and the banked memory; it sequences the request/stall/fixed-latency response protocol on the memory side.

Parameters:
MEM_LAT, 4, cycles from memory request acceptance to valid mem_rdata (legal range 1..15)
STARVE_MAX, 8, consecutive cycles i_req may be denied before the I-cache beats the D-cache (legal range 1..15)

Ports:
clk  in  1  system clock, all state updates on posedge
rst  in  1  asynchronous, active-high reset
i_req  in  1  I-cache read request; held until i_grant
i_addr  in  16  I-cache word address
i_grant  out  1  one-cycle pulse, I request captured this cycle
i_done  out  1  one-cycle pulse, rdata valid for I
d_req  in  1  D-cache request; held until d_grant
d_wr  in  1  1 = write, 0 = read
d_addr  in  16  D-cache address
d_wdata  in  16  D-cache write data
d_grant  out  1  one-cycle pulse, D request captured this cycle
d_done  out  1  one-cycle pulse, D transaction complete / rdata valid
rdata  out  16  registered read data, shared by both requesters
busy  out  1  high in every state except IDLE
mem_rd  out  1  memory read strobe
mem_wr  out  1  memory write strobe
mem_addr  out  16  memory address
mem_wdata  out  16  memory write data
mem_stall  in  1  memory cannot accept the request this cycle (bank busy)
mem_rdata  in  16  memory read data, valid MEM_LAT cycles after acceptance

Behaviour:
- Reset (async, any state, including mid-transaction):
  - state = IDLE; owner, address, wdata, wr and rdata registers = 0; wait_ctr and lat_ctr = 0.
  - All outputs are 0.
  - An in-flight transaction is abandoned: no done pulse, no retry.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE arbitration (combinational grant; capture at the clock edge):
  - If i_req && wait_ctr >= STARVE_MAX: grant I.
  - Else if d_req: grant D.
  - Else if i_req: grant I.
  - Else stay IDLE.
  - On grant: latch owner, addr, wr (I is always a read), wdata; move to ISSUE.
  - The requester may drop req after the grant cycle.
- wait_ctr (4-bit, saturating at 15):
  - Increments each IDLE cycle in which i_req=1 and D is granted.
  - Also increments each non-IDLE cycle while i_req=1.
  - Clears when I is granted or when i_req=0.
- ISSUE:
  - Drive mem_rd = !wr_q, mem_wr = wr_q, mem_addr/mem_wdata from the latched registers.
  - If mem_stall=1: hold all strobes and data and stay in ISSUE, with no timeout.
  - If mem_stall=0: the request is accepted; load lat_ctr = MEM_LAT-1; go to WAIT.
- Memory-side outputs are 0 in every state except ISSUE.
- WAIT:
  - If lat_ctr == 0: rdata <= mem_rdata (reads only; rdata unchanged for writes); go to RESP.
  - Else lat_ctr decrements.
- RESP: assert owner's done for one cycle; go to IDLE.
- Timing: new arbitration happens the cycle after RESP, so there is one dead cycle between transactions.
- Latency, with grant in cycle 0 and no stall:
  - accept in cycle 1;
  - mem_rdata sampled at the end of cycle 1+MEM_LAT;
  - done in cycle 2+MEM_LAT;
  - earliest next grant in cycle 3+MEM_LAT.
  - Each stall cycle adds 1.
- rdata holds its value until the next read completes.
- Simultaneous i_req/d_req with wait_ctr < STARVE_MAX: D wins; wait_ctr increments.
- Requests asserted while busy are ignored; requesters keep req high until granted.
- i_grant, d_grant, i_done and d_done are mutually exclusive every cycle.

Test Plan:
1. I read only, MEM_LAT=4: i_req=1, i_addr=0x0040, mem_rdata=0xBEEF in cycle 5 -> i_grant cycle 0; mem_rd=1, mem_addr=0x0040 cycle 1; i_done=1, rdata=0xBEEF cycle 6; busy cycles 1-6.
2. D write with stall: d_req=1, d_wr=1, d_addr=0x1234, d_wdata=0xA5A5; mem_stall=1 for cycles 1-2 -> mem_wr=1, mem_addr/mem_wdata held for cycles 1-3; accept cycle 3; d_done cycle 8; rdata unchanged.
3. Simultaneous i_req and d_req from cycle 0, both held -> d_grant cycle 0, d_done cycle 6, i_grant cycle 7.
4. Starvation, STARVE_MAX=8, MEM_LAT=1: d_req held continuously, i_req held -> D granted repeatedly until wait_ctr reaches 8; the next IDLE grants I even though d_req=1; wait_ctr then clears to 0.
5. Reset mid-WAIT: rst pulsed asynchronously in cycle 3 of an I read -> all outputs 0 immediately; no i_done; after release, a fresh i_req is granted in its first IDLE cycle.
6. Back-to-back D read then D write, MEM_LAT=2 -> read done cycle 4, write granted cycle 5; rdata keeps the read value through the write's d_done.
